// File: rtl/fsm_light_monitor.sv
// Receive-side safety monitor for the traffic-light code stream: drives the lamps,
// measures phase dwell, checks order and timing, and latches the first fault seen.
module fsm_light_monitor #(
    parameter int unsigned RED_T = 25,
    parameter int unsigned PED_T = 21,
    parameter int unsigned YEL_T = 5,
    parameter int unsigned GRN_T = 30,
    parameter int unsigned EMG_T = 21,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       light,
    input  logic             clr_err,
    output logic [4:0]       lamp,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dwell_cnt,
    output logic             fault,
    output logic [2:0]       err_code,
    output logic [7:0]       cycle_cnt
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_LONG    = 3'd4;

    state_t      state, state_nxt;
    logic [4:0]  light_q;
    logic [2:0]  err_nxt;
    logic        count_seq;
    logic        chg;
    logic        light_ok;
    int unsigned dwell_ext;

    // Legal phase order is RED(0) -> PED(1) -> YEL(3) -> GRN(2) -> EMG(4) -> RED.
    function automatic logic [4:0] succ(input logic [4:0] c);
        case (c)
            5'd0:    return 5'd1;
            5'd1:    return 5'd3;
            5'd3:    return 5'd2;
            5'd2:    return 5'd4;
            5'd4:    return 5'd0;
            default: return 5'h1f;
        endcase
    endfunction

    function automatic int unsigned exp_dwell(input logic [4:0] c);
        case (c)
            5'd0:    return RED_T;
            5'd1:    return PED_T;
            5'd3:    return YEL_T;
            5'd2:    return GRN_T;
            5'd4:    return EMG_T;
            default: return 0;
        endcase
    endfunction

    assign chg       = (light != light_q);
    assign light_ok  = (light <= 5'd4);
    assign dwell_ext = {{(32-CNT_W){1'b0}}, dwell_cnt};

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        count_seq = 1'b0;
        case (state)
            ACQUIRE: begin
                if (!light_ok) begin
                    state_nxt = FAULT;
                    err_nxt   = ERR_ILLEGAL;
                end else if (chg) begin
                    if (light == succ(light_q)) begin
                        state_nxt = TRACK;
                    end else begin
                        state_nxt = FAULT;
                        err_nxt   = ERR_ORDER;
                    end
                end
            end
            TRACK: begin
                if (!light_ok) begin
                    state_nxt = FAULT;
                    err_nxt   = ERR_ILLEGAL;
                end else if (chg) begin
                    if (light != succ(light_q)) begin
                        state_nxt = FAULT;
                        err_nxt   = ERR_ORDER;
                    end else if (dwell_ext < exp_dwell(light_q)) begin
                        state_nxt = FAULT;
                        err_nxt   = ERR_SHORT;
                    end else begin
                        count_seq = (light_q == 5'd4) && (light == 5'd0);
                    end
                end else if (dwell_ext == exp_dwell(light_q)) begin
                    // Holding one more cycle would push the phase past its dwell.
                    state_nxt = FAULT;
                    err_nxt   = ERR_LONG;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_nxt = ACQUIRE;
                    err_nxt   = ERR_NONE;
                end
            end
            default: begin
                state_nxt = ACQUIRE;
                err_nxt   = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACQUIRE;
            light_q     <= 5'd0;
            lamp        <= 5'd0;
            dwell_cnt   <= '0;
            phase_valid <= 1'b0;
            fault       <= 1'b0;
            err_code    <= ERR_NONE;
            cycle_cnt   <= 8'd0;
        end else begin
            state       <= state_nxt;
            light_q     <= light;
            lamp        <= light_ok ? (5'b00001 << light) : 5'b00000;
            phase_valid <= (state_nxt == TRACK);
            fault       <= (state_nxt == FAULT);
            err_code    <= err_nxt;
            if (chg) begin
                dwell_cnt <= CNT_W'(1);
            end else if (dwell_cnt != {CNT_W{1'b1}}) begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
            if (count_seq && (cycle_cnt != 8'hff)) begin
                cycle_cnt <= cycle_cnt + 8'd1;
            end
        end
    end

endmodule
